// File: rtl/stack_port_arbiter_if.sv
// rtl/stack_port_arbiter_if.sv - requester-side request/response bundle for stack_port_arbiter
//
// Purpose: carries the two requesters' request handshake and the shared
// one-hot response back from the arbiter.
// Signals:
//   req_valid  [1:0]          request valid, bit n = requester n
//   req_push   [1:0]          1 = push, 0 = pop, per requester
//   req_data   [2*D_WIDTH-1:0] push data, requester n in [n*D_WIDTH +: D_WIDTH]
//   req_ready  [1:0]          one-hot accept strobe
//   resp_valid [1:0]          one-hot, one-cycle completion pulse
//   resp_data  [D_WIDTH-1:0]  pop data, 0 for push or error
//   resp_err                  qualifies resp_valid, 1 = overflow/underflow
// Modports: master = requester side, slave = arbiter side.
interface stack_port_arbiter_if #(
    parameter int D_WIDTH = 34
);
    logic [1:0]           req_valid;
    logic [1:0]           req_push;
    logic [2*D_WIDTH-1:0] req_data;
    logic [1:0]           req_ready;
    logic [1:0]           resp_valid;
    logic [D_WIDTH-1:0]   resp_data;
    logic                 resp_err;

    modport master (
        output req_valid, req_push, req_data,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_push, req_data,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/stack_port_arbiter.sv
// rtl/stack_port_arbiter.sv - two-requester arbiter in front of a shared push/pop stack
//
// Purpose: grants one of two requesters (r0 call/return, r1 interrupt/context
// save), rejects overflow/underflow, sequences the stack strobes and returns
// pop data to the winner. One operation in flight at a time.
// Ports:
//   clk, reset        clock (rising edge), synchronous active-high reset
//   rq                requester bundle (stack_port_arbiter_if.slave)
//   stk_reset_o       reset to stack: reset plus one cycle after release
//   stk_we_o          stack operation strobe (ISSUE only)
//   stk_push_o        stack direction (ISSUE only)
//   stk_wdata_o       stack write data (ISSUE only)
//   stk_pop_i         stack pop data, valid POP_LAT cycles after the strobe
//   depth_o           current entry count
//   full_o, empty_o   depth at capacity / depth zero
// Build option: STACK_ARB_FIXED_PRIO_EN selects fixed priority (r0 wins ties)
// instead of round-robin.
module stack_port_arbiter #(
    parameter int D_WIDTH    = 34,
    parameter int DEPTH_LOG2 = 5,
    parameter int POP_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    stack_port_arbiter_if.slave   rq,
    output logic                  stk_reset_o,
    output logic                  stk_we_o,
    output logic                  stk_push_o,
    output logic [D_WIDTH-1:0]    stk_wdata_o,
    input  logic [D_WIDTH-1:0]    stk_pop_i,
    output logic [DEPTH_LOG2:0]   depth_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int                CAP_I = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CAP = (DEPTH_LOG2+1)'(CAP_I);

    logic [1:0]          state;
    logic [DEPTH_LOG2:0] depth;
    logic                grant_q;
    logic                push_q;
    logic                err_q;
    logic [D_WIDTH-1:0]  data_q;
    logic [D_WIDTH-1:0]  pop_q;
    logic [2:0]          wait_cnt;
    logic                reset_q;

    logic                gsel;
    logic                accept;
    logic                sel_push;
    logic [D_WIDTH-1:0]  sel_data;
    logic                legal;

`ifndef STACK_ARB_FIXED_PRIO_EN
    logic                last_grant;
`endif

    // The stack stays in reset for one extra cycle after release so it is
    // settled before the first strobe; requests are held off meanwhile.
    always_ff @(posedge clk) begin
        reset_q <= reset;
    end

    assign stk_reset_o = reset | reset_q;

    always_comb begin
        gsel = 1'b0;
        case (rq.req_valid)
            2'b10:   gsel = 1'b1;
`ifdef STACK_ARB_FIXED_PRIO_EN
            2'b11:   gsel = 1'b0;
`else
            2'b11:   gsel = ~last_grant;
`endif
            default: gsel = 1'b0;
        endcase
    end

    assign accept   = (state == S_IDLE) && (|rq.req_valid) && !stk_reset_o;
    assign sel_push = gsel ? rq.req_push[1] : rq.req_push[0];
    assign sel_data = gsel ? rq.req_data[2*D_WIDTH-1:D_WIDTH] : rq.req_data[D_WIDTH-1:0];
    assign legal    = sel_push ? !full_o : !empty_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            depth    <= '0;
            grant_q  <= 1'b0;
            push_q   <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= '0;
            pop_q    <= '0;
            wait_cnt <= '0;
`ifndef STACK_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        grant_q <= gsel;
                        push_q  <= sel_push;
                        data_q  <= sel_data;
                        err_q   <= !legal;
                        pop_q   <= '0;
                        state   <= legal ? S_ISSUE : S_RESP;
`ifndef STACK_ARB_FIXED_PRIO_EN
                        last_grant <= gsel;
`endif
                    end
                end
                S_ISSUE: begin
                    depth    <= push_q ? depth + 1'b1 : depth - 1'b1;
                    wait_cnt <= '0;
                    state    <= push_q ? S_RESP : S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == 3'(POP_LAT - 1)) begin
                        pop_q <= stk_pop_i;
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign rq.req_ready  = accept ? (gsel ? 2'b10 : 2'b01) : 2'b00;
    assign rq.resp_valid = (state == S_RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign rq.resp_err   = (state == S_RESP) && err_q;
    assign rq.resp_data  = ((state == S_RESP) && !err_q) ? pop_q : '0;

    assign stk_we_o    = (state == S_ISSUE);
    assign stk_push_o  = (state == S_ISSUE) && push_q;
    assign stk_wdata_o = (state == S_ISSUE) ? data_q : '0;

    assign depth_o = depth;
    assign full_o  = (depth == CAP);
    assign empty_o = (depth == '0);
endmodule

// File: tb/tb_stack_port_arbiter.sv
// tb/tb_stack_port_arbiter.sv - self-checking bench for stack_port_arbiter
module tb_stack_port_arbiter;
    localparam int DW      = 34;
    localparam int DL      = 5;
    localparam int POP_LAT = 1;
    localparam int CAP     = 2 ** DL;
    localparam logic [DW-1:0] JUNK = 34'h3_DEAD_BEEF;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          stk_reset_o, stk_we_o, stk_push_o;
    logic [DW-1:0] stk_wdata_o, stk_pop_i;
    logic [DL:0]   depth_o;
    logic          full_o, empty_o;

    stack_port_arbiter_if #(.D_WIDTH(DW)) rq ();

    stack_port_arbiter #(.D_WIDTH(DW), .DEPTH_LOG2(DL), .POP_LAT(POP_LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .rq          (rq),
        .stk_reset_o (stk_reset_o),
        .stk_we_o    (stk_we_o),
        .stk_push_o  (stk_push_o),
        .stk_wdata_o (stk_wdata_o),
        .stk_pop_i   (stk_pop_i),
        .depth_o     (depth_o),
        .full_o      (full_o),
        .empty_o     (empty_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Stack instance stand-in: real LIFO storage, pop data appears POP_LAT
    // cycles after the strobe and junk otherwise, so mistimed capture shows.
    bit            ovr_en = 1'b0;
    logic [DW-1:0] ovr_val = 34'h2AB;
    logic [DW-1:0] stk_mem [$];
    logic [DW-1:0] pipe [POP_LAT];
    logic [DW-1:0] pv_tmp;

    always @(posedge clk) begin
        if (stk_reset_o) begin
            stk_mem.delete();
            pipe[0] <= JUNK;
        end else if (stk_we_o && stk_push_o) begin
            stk_mem.push_back(stk_wdata_o);
            pipe[0] <= JUNK;
        end else if (stk_we_o) begin
            pv_tmp = (stk_mem.size() > 0) ? stk_mem.pop_back() : JUNK;
            pipe[0] <= ovr_en ? ovr_val : pv_tmp;
        end else begin
            pipe[0] <= JUNK;
        end
        for (int k = 1; k < POP_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign stk_pop_i = pipe[POP_LAT-1];

    // Reference model: pending requests, expected stack contents, last grant.
    bit [1:0]      pv, pp;
    logic [DW-1:0] pd [2];
    logic [DW-1:0] m_q [$];
    bit            m_last = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        rq.req_valid = pv;
        rq.req_push  = pp;
        rq.req_data  = {pd[1], pd[0]};
    endtask

    function automatic int exp_grant();
        if (pv == 2'b11) begin
`ifdef STACK_ARB_FIXED_PRIO_EN
            return 0;
`else
            return m_last ? 0 : 1;
`endif
        end
        return pv[1] ? 1 : 0;
    endfunction

    task automatic do_reset(input string tag);
        @(negedge clk); reset = 1'b1; drive();
        @(negedge clk); #1;
        chk({tag, ".rst.ready"},  rq.req_ready, 0);
        chk({tag, ".rst.rvalid"}, rq.resp_valid, 0);
        chk({tag, ".rst.rerr"},   rq.resp_err, 0);
        chk({tag, ".rst.rdata"},  rq.resp_data, 0);
        chk({tag, ".rst.we"},     {stk_we_o, stk_push_o}, 0);
        chk({tag, ".rst.wdata"},  stk_wdata_o, 0);
        chk({tag, ".rst.depth"},  depth_o, 0);
        chk({tag, ".rst.flags"},  {full_o, empty_o}, 2'b01);
        chk({tag, ".rst.stkrst"}, stk_reset_o, 1);
        @(negedge clk); reset = 1'b0; drive(); #1;
        chk({tag, ".post.stkrst"}, stk_reset_o, 1);
        chk({tag, ".post.ready"},  rq.req_ready, 0);
        m_q.delete();
        m_last = 1'b1;
    endtask

    // One complete transaction from the pending request set, checked cycle
    // by cycle against the latency rules. Returns the expected winner.
    task automatic transact(input string tag, output int g);
        int            n, lat;
        bit            legal, op;
        logic [DW-1:0] wd, exp_d;
        @(negedge clk); drive(); #1;
        n = 0;
        while (rq.req_ready == 2'b00 && n < 10) begin
            @(negedge clk); #1; n++;
        end
        g = exp_grant();
        chk({tag, ".grant"}, rq.req_ready, 2'b01 << g);
        op    = pp[g];
        wd    = pd[g];
        legal = op ? (m_q.size() < CAP) : (m_q.size() > 0);
        exp_d = (op || !legal) ? '0 : (ovr_en ? ovr_val : m_q[m_q.size()-1]);
        lat   = !legal ? 1 : (op ? 2 : 2 + POP_LAT);
        m_last = g[0];
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                pv[g] = 1'b0;
                drive();
            end
            #1;
            chk({tag, ".ready_busy"}, rq.req_ready, 0);
            chk({tag, ".we"}, stk_we_o, (legal && k == 1));
            if (legal && k == 1) begin
                chk({tag, ".push"},  stk_push_o, op);
                chk({tag, ".wdata"}, stk_wdata_o, wd);
            end
            if (k == lat) begin
                if (legal) begin
                    if (op) m_q.push_back(wd);
                    else    void'(m_q.pop_back());
                end
                chk({tag, ".rvalid"}, rq.resp_valid, 2'b01 << g);
                chk({tag, ".rerr"},   rq.resp_err, !legal);
                chk({tag, ".rdata"},  rq.resp_data, exp_d);
                chk({tag, ".depth"},  depth_o, m_q.size());
                chk({tag, ".flags"},  {full_o, empty_o}, {m_q.size() == CAP, m_q.size() == 0});
            end else begin
                chk({tag, ".rvalid_early"}, rq.resp_valid, 0);
            end
        end
    endtask

    initial begin
        int g;
        pv = 2'b00; pp = 2'b00; pd[0] = '0; pd[1] = '0;
        drive();
        do_reset("init");

        // Push 0x1, then a pop that the stack answers with 0x2AB.
        pv = 2'b01; pp = 2'b01; pd[0] = 34'h1;
        transact("push1", g);
        ovr_en = 1'b1;
        pv = 2'b01; pp = 2'b00;
        transact("pop2ab", g);
        ovr_en = 1'b0;

        // Underflow on the empty stack.
        pv = 2'b01; pp = 2'b00;
        transact("underflow", g);

        // Fill to capacity, then overflow, then a LIFO pop at full.
        for (int i = 0; i < CAP; i++) begin
            pv = 2'b01; pp = 2'b01; pd[0] = DW'(i + 34'h100);
            transact("fill", g);
        end
        pv = 2'b01; pp = 2'b01; pd[0] = 34'h3FF;
        transact("overflow", g);
        pv = 2'b10; pp = 2'b00;
        transact("pop_full", g);

        // Both requesters pushing continuously.
        pv = 2'b00;
        do_reset("tie");
        pp = 2'b11; pd[0] = 34'hA0; pd[1] = 34'hB0;
        pv = 2'b11;
        for (int i = 0; i < 4; i++) begin
            transact("tie", g);
            pv[g] = 1'b1;
            pd[g] = pd[g] + 1'b1;
        end

        // Reset during the WAIT cycle of a pop.
        pv = 2'b00;
        do_reset("abort");
        pv = 2'b01; pp = 2'b01; pd[0] = 34'h11;
        transact("abort.push_a", g);
        pv = 2'b01; pp = 2'b01; pd[0] = 34'h22;
        transact("abort.push_b", g);
        @(negedge clk); pv = 2'b01; pp = 2'b00; drive(); #1;
        chk("abort.pop_ready", rq.req_ready, 2'b01);
        @(negedge clk); pv = 2'b10; pp = 2'b10; pd[1] = 34'h33; drive(); #1;
        chk("abort.issue_we", stk_we_o, 1);
        @(negedge clk); reset = 1'b1; #1;
        chk("abort.wait_rvalid", rq.resp_valid, 0);
        chk("abort.wait_depth", depth_o, 1);
        @(negedge clk); reset = 1'b0; #1;
        chk("abort.post_rvalid", rq.resp_valid, 0);
        chk("abort.post_depth", depth_o, 0);
        chk("abort.post_stkrst", stk_reset_o, 1);
        chk("abort.post_ready", rq.req_ready, 0);
        m_q.delete();
        m_last = 1'b1;
        transact("abort.r1", g);
        chk("abort.r1_who", g, 1);

        // Randomized traffic from both requesters.
        pv = 2'b00;
        do_reset("rand");
        pv = 2'b11; pp = 2'($urandom_range(0, 3));
        pd[0] = DW'({$urandom, $urandom}); pd[1] = DW'({$urandom, $urandom});
        for (int i = 0; i < 80; i++) begin
            transact("rand", g);
            pv[g] = ($urandom_range(0, 3) != 0);
            pp[g] = ($urandom_range(0, 2) != 0);
            pd[g] = DW'({$urandom, $urandom});
            if (pv == 2'b00) pv[$urandom_range(0, 1)] = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
